wakeup_select_n: RTL and testbench

- Parametrised successor of the two-wide wakeup/select stage.
- Each cycle it picks up to ISSUE_W executable reservation-buffer entries, highest tag first.
- Picked entries go into per-slot output registers that hold under a valid/ready handshake with the execution units.
- A grant mask returns to the buffer so it can mark captured entries as issued; a flush input kills all in-flight slots.

---
 rtl/wakeup_select_n_if.sv | 23 ++
 rtl/wakeup_select_n.sv | 124 ++++++++++++
 tb/tb_wakeup_select_n.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wakeup_select_n_if.sv
// Issue-side handshake bundle of wakeup_select_n: per-slot valid/ready plus the
// captured tag, address-generation flag and opaque payload.
interface wakeup_select_n_if #(
    parameter int ISSUE_W   = 2,
    parameter int TAG_W     = 5,
    parameter int PAYLOAD_W = 128
);
    logic [ISSUE_W-1:0]           issue_valid;
    logic [ISSUE_W-1:0]           issue_ready;
    logic [ISSUE_W*TAG_W-1:0]     issue_tag;
    logic [ISSUE_W-1:0]           issue_gen_addr;
    logic [ISSUE_W*PAYLOAD_W-1:0] issue_payload;

    modport master (
        output issue_valid, issue_tag, issue_gen_addr, issue_payload,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, issue_tag, issue_gen_addr, issue_payload,
        output issue_ready
    );
endinterface

// File: rtl/wakeup_select_n.sv
// Wakeup/select stage: each cycle moves up to ISSUE_W executable reservation-buffer
// entries, highest tag first, into valid/ready issue slot registers.
module wakeup_select_n #(
    parameter int BUF_SIZE  = 16,
    parameter int TAG_W     = 5,
    parameter int ISSUE_W   = 2,
    parameter int PAYLOAD_W = 128
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          is_tag_flooded,
    input  logic [BUF_SIZE-1:0]           ent_exec,
    input  logic [BUF_SIZE-1:0]           ent_gen_addr,
    input  logic [BUF_SIZE*TAG_W-1:0]     ent_tag,
    input  logic [BUF_SIZE*PAYLOAD_W-1:0] ent_payload,
    output logic [BUF_SIZE-1:0]           grant,
    output logic [31:0]                   issue_count,
    wakeup_select_n_if.master             issue
);

    logic [TAG_W-1:0]     tag_arr   [BUF_SIZE];
    int                   rank      [BUF_SIZE];
    logic [ISSUE_W-1:0]   slot_free;
    int                   free_rank [ISSUE_W];
    logic [ISSUE_W-1:0]   slot_load;
    logic [TAG_W-1:0]     cap_tag   [ISSUE_W];
    logic                 cap_ga    [ISSUE_W];
    logic [PAYLOAD_W-1:0] cap_pay   [ISSUE_W];
    int                   accepted;
    logic [32:0]          count_sum;

    // Rank of each candidate = number of candidates that beat it; ranks are unique.
    always_comb begin : rank_calc
        // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
        for (int i = 0; i < BUF_SIZE; i++) begin
            tag_arr[i] = ent_tag[i*TAG_W +: TAG_W];
        end
        for (int i = 0; i < BUF_SIZE; i++) begin
            rank[i] = 0;
            for (int j = 0; j < BUF_SIZE; j++) begin
                if (ent_exec[j] && ((tag_arr[j] > tag_arr[i]) ||
                                    ((tag_arr[j] == tag_arr[i]) && (j < i)))) begin
                    rank[i] = rank[i] + 1;
                end
            end
        end
    end

    // The n-th free slot (ascending) receives the candidate of rank n.
    always_comb begin : slot_calc
        for (int k = 0; k < ISSUE_W; k++) begin
            slot_free[k] = !issue.issue_valid[k] || issue.issue_ready[k];
            free_rank[k] = 0;
            for (int m = 0; m < k; m++) begin
                if (!issue.issue_valid[m] || issue.issue_ready[m]) begin
                    free_rank[k] = free_rank[k] + 1;
                end
            end
        end
    end

    always_comb begin : select_calc
        grant     = '0;
        slot_load = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            cap_tag[k] = '0;
            cap_ga[k]  = 1'b0;
            cap_pay[k] = '0;
        end
        if (rst_n && !flush) begin
            for (int k = 0; k < ISSUE_W; k++) begin
                for (int i = 0; i < BUF_SIZE; i++) begin
                    if (slot_free[k] && ent_exec[i] && (rank[i] == free_rank[k])) begin
                        slot_load[k] = 1'b1;
                        grant[i]     = 1'b1;
                        cap_tag[k]   = tag_arr[i];
                        cap_ga[k]    = ent_gen_addr[i];
                        cap_pay[k]   = ent_payload[i*PAYLOAD_W +: PAYLOAD_W];
                    end
                end
                cap_tag[k][TAG_W-1] = cap_tag[k][TAG_W-1] | is_tag_flooded;
            end
        end
    end

    always_comb begin : count_calc
        accepted = 0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (issue.issue_valid[k] && issue.issue_ready[k]) begin
                accepted = accepted + 1;
            end
        end
        count_sum = {1'b0, issue_count} + 33'(accepted);
    end

    // Flush wins over capture; accepted handshakes still count during a flush.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            // NOTE: payload registers are reset too, since idle slots must read back as zero after reset.
            issue.issue_valid    <= '0;
            issue.issue_tag      <= '0;
            issue.issue_gen_addr <= '0;
            issue.issue_payload  <= '0;
            issue_count          <= '0;
        end else begin
            issue_count <= count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];
            for (int k = 0; k < ISSUE_W; k++) begin
                if (flush) begin
                    issue.issue_valid[k] <= 1'b0;
                end else if (slot_load[k]) begin
                    issue.issue_valid[k]                         <= 1'b1;
                    issue.issue_tag[k*TAG_W +: TAG_W]            <= cap_tag[k];
                    issue.issue_gen_addr[k]                      <= cap_ga[k];
                    issue.issue_payload[k*PAYLOAD_W +: PAYLOAD_W] <= cap_pay[k];
                end else if (slot_free[k]) begin
                    issue.issue_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wakeup_select_n.sv
// Self-checking bench for wakeup_select_n: directed scenarios with literal
// expectations followed by randomized traffic against a queue-based model.
module tb_wakeup_select_n;

    localparam int BUF_SIZE  = 16;
    localparam int TAG_W     = 5;
    localparam int ISSUE_W   = 2;
    localparam int PAYLOAD_W = 128;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          flush;
    logic                          is_tag_flooded;
    logic [BUF_SIZE-1:0]           ent_exec;
    logic [BUF_SIZE-1:0]           ent_gen_addr;
    logic [BUF_SIZE*TAG_W-1:0]     ent_tag;
    logic [BUF_SIZE*PAYLOAD_W-1:0] ent_payload;
    logic [BUF_SIZE-1:0]           grant;
    logic [31:0]                   issue_count;

    wakeup_select_n_if #(.ISSUE_W(ISSUE_W), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)) issue_if ();

    wakeup_select_n #(
        .BUF_SIZE(BUF_SIZE), .TAG_W(TAG_W), .ISSUE_W(ISSUE_W), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .is_tag_flooded (is_tag_flooded),
        .ent_exec       (ent_exec),
        .ent_gen_addr   (ent_gen_addr),
        .ent_tag        (ent_tag),
        .ent_payload    (ent_payload),
        .grant          (grant),
        .issue_count    (issue_count),
        .issue          (issue_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: what each slot must hold, plus the unbounded handshake tally.
    bit                   m_valid [ISSUE_W];
    logic [TAG_W-1:0]     m_tag   [ISSUE_W];
    bit                   m_ga    [ISSUE_W];
    logic [PAYLOAD_W-1:0] m_pay   [ISSUE_W];
    longint unsigned      m_count;
    int                   m_assign [ISSUE_W];
    logic [BUF_SIZE-1:0]  exp_grant;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PAYLOAD_W-1:0] pay_of(input int i);
        return {4{32'hA000_0000 + 32'(i)}};
    endfunction

    function automatic logic [TAG_W-1:0] tag_in(input int i);
        return ent_tag[i*TAG_W +: TAG_W];
    endfunction

    task automatic set_tag(input int i, input logic [TAG_W-1:0] t);
        ent_tag[i*TAG_W +: TAG_W] = t;
    endtask

    task automatic defaults();
        flush          = 1'b0;
        is_tag_flooded = 1'b0;
        ent_exec       = '0;
        ent_gen_addr   = '0;
        ent_tag        = '0;
        for (int i = 0; i < BUF_SIZE; i++) ent_payload[i*PAYLOAD_W +: PAYLOAD_W] = pay_of(i);
        issue_if.issue_ready = '0;
    endtask

    // Hand out candidates best-first to free slots in ascending order.
    task automatic model_select();
        int  cands[$];
        exp_grant = '0;
        for (int k = 0; k < ISSUE_W; k++) m_assign[k] = -1;
        if (!rst_n || flush) return;
        for (int i = 0; i < BUF_SIZE; i++) if (ent_exec[i]) cands.push_back(i);
        for (int k = 0; k < ISSUE_W; k++) begin
            if (m_valid[k] && !issue_if.issue_ready[k]) continue;
            if (cands.size() == 0) break;
            begin
                int best = 0;
                for (int c = 1; c < cands.size(); c++) begin
                    if (tag_in(cands[c]) > tag_in(cands[best])) best = c;
                    else if (tag_in(cands[c]) == tag_in(cands[best]) && cands[c] < cands[best]) best = c;
                end
                m_assign[k] = cands[best];
                exp_grant[cands[best]] = 1'b1;
                cands.delete(best);
            end
        end
    endtask

    task automatic model_update();
        int acc = 0;
        if (!rst_n) begin
            for (int k = 0; k < ISSUE_W; k++) begin
                m_valid[k] = 0; m_tag[k] = '0; m_ga[k] = 0; m_pay[k] = '0;
            end
            m_count = 0;
            return;
        end
        for (int k = 0; k < ISSUE_W; k++) if (m_valid[k] && issue_if.issue_ready[k]) acc++;
        m_count = m_count + longint'(acc);
        if (m_count > 64'hFFFF_FFFF) m_count = 64'hFFFF_FFFF;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (flush) m_valid[k] = 0;
            else if (m_assign[k] >= 0) begin
                m_valid[k] = 1;
                m_tag[k]   = tag_in(m_assign[k]);
                if (is_tag_flooded) m_tag[k][TAG_W-1] = 1'b1;
                m_ga[k]    = ent_gen_addr[m_assign[k]];
                m_pay[k]   = ent_payload[m_assign[k]*PAYLOAD_W +: PAYLOAD_W];
            end else if (issue_if.issue_ready[k]) m_valid[k] = 0;
        end
    endtask

    task automatic compare_state();
        logic [ISSUE_W-1:0] mv;
        for (int k = 0; k < ISSUE_W; k++) mv[k] = m_valid[k];
        check("issue_valid", 128'(issue_if.issue_valid), 128'(mv));
        check("issue_count", 128'(issue_count), 128'(m_count));
        for (int k = 0; k < ISSUE_W; k++) begin
            if (m_valid[k]) begin
                check($sformatf("issue_tag[%0d]", k), 128'(issue_if.issue_tag[k*TAG_W +: TAG_W]), 128'(m_tag[k]));
                check($sformatf("issue_gen_addr[%0d]", k), 128'(issue_if.issue_gen_addr[k]), 128'(m_ga[k]));
                check($sformatf("issue_payload[%0d]", k), issue_if.issue_payload[k*PAYLOAD_W +: PAYLOAD_W], m_pay[k]);
            end
        end
    endtask

    // Inputs are driven just after a negedge; check, take the edge, advance the model.
    task automatic step(input bit use_lit, input logic [BUF_SIZE-1:0] lit_grant);
        #1;
        model_select();
        check("grant", 128'(grant), 128'(exp_grant));
        if (use_lit) check("grant_literal", 128'(grant), 128'(lit_grant));
        compare_state();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_slots();
        defaults();
        issue_if.issue_ready = '1;
        step(1'b0, '0);
        issue_if.issue_ready = '0;
    endtask

    function automatic logic [TAG_W-1:0] slot_tag(input int k);
        return issue_if.issue_tag[k*TAG_W +: TAG_W];
    endfunction

    initial begin
        longint unsigned cnt_before;
        for (int k = 0; k < ISSUE_W; k++) begin
            m_valid[k] = 0; m_tag[k] = '0; m_ga[k] = 0; m_pay[k] = '0; m_assign[k] = -1;
        end
        m_count = 0;

        // Reset held with every entry executable.
        rst_n = 1'b0;
        defaults();
        ent_exec = '1;
        for (int i = 0; i < BUF_SIZE; i++) set_tag(i, TAG_W'(i));
        issue_if.issue_ready = '1;
        @(negedge clk);
        step(1'b1, '0);
        check("rst_valid", 128'(issue_if.issue_valid), 128'(0));
        check("rst_count", 128'(issue_count), 128'(0));
        rst_n = 1'b1;
        step(1'b1, 16'hC000);
        check("post_rst_valid", 128'(issue_if.issue_valid), 128'(2'b11));
        check("post_rst_tag0", 128'(slot_tag(0)), 128'(15));
        check("post_rst_tag1", 128'(slot_tag(1)), 128'(14));

        // Priority with a tag tie resolved by lower entry index.
        clear_slots();
        ent_exec = 16'h0288;
        set_tag(3, 5'd4); set_tag(7, 5'd12); set_tag(9, 5'd12);
        issue_if.issue_ready = 2'b11;
        step(1'b1, 16'h0280);
        check("prio_tag0", 128'(slot_tag(0)), 128'(12));
        check("prio_tag1", 128'(slot_tag(1)), 128'(12));
        check("prio_pay0", issue_if.issue_payload[0 +: PAYLOAD_W], pay_of(7));
        check("prio_pay1", issue_if.issue_payload[PAYLOAD_W +: PAYLOAD_W], pay_of(9));

        // Slot 0 stalled, slot 1 accepted: only the best candidate refills slot 1.
        defaults();
        ent_exec = 16'h0024;
        set_tag(2, 5'd6); set_tag(5, 5'd9);
        issue_if.issue_ready = 2'b10;
        step(1'b1, 16'h0020);
        check("stall_tag0", 128'(slot_tag(0)), 128'(12));
        check("stall_pay0", issue_if.issue_payload[0 +: PAYLOAD_W], pay_of(7));
        check("stall_tag1", 128'(slot_tag(1)), 128'(9));

        // Flooded tag.
        clear_slots();
        is_tag_flooded = 1'b1;
        ent_exec = 16'h0001;
        set_tag(0, 5'b00011);
        step(1'b1, 16'h0001);
        check("flood_tag", 128'(slot_tag(0)), 128'(5'b10011));

        // Flush with one handshake in the same cycle.
        clear_slots();
        ent_exec = 16'h0006;
        step(1'b1, 16'h0006);
        defaults();
        flush = 1'b1;
        ent_exec = 16'h0010;
        issue_if.issue_ready = 2'b01;
        cnt_before = m_count;
        step(1'b1, 16'h0000);
        check("flush_valid", 128'(issue_if.issue_valid), 128'(0));
        check("flush_count", 128'(issue_count), 128'(cnt_before + 1));

        // Saturation of the handshake counter.
        defaults();
        ent_exec = 16'h0006;
        step(1'b0, '0);
        force dut.issue_count = 32'hFFFF_FFFE;
        #1;
        release dut.issue_count;
        m_count = 64'hFFFF_FFFE;
        defaults();
        ent_exec = 16'h0018;
        issue_if.issue_ready = 2'b11;
        step(1'b0, '0);
        check("sat_first", 128'(issue_count), 128'(32'hFFFF_FFFF));
        ent_exec = 16'h0060;
        step(1'b0, '0);
        check("sat_hold", 128'(issue_count), 128'(32'hFFFF_FFFF));

        // Randomized traffic, including ties, stalls, flushes and occasional reset.
        for (int n = 0; n < 2000; n++) begin
            rst_n          = ($urandom_range(0, 99) != 0);
            flush          = ($urandom_range(0, 15) == 0);
            is_tag_flooded = ($urandom_range(0, 7) == 0);
            ent_exec       = 16'($urandom) & 16'($urandom);
            ent_gen_addr   = 16'($urandom);
            for (int i = 0; i < BUF_SIZE; i++) begin
                set_tag(i, (n % 3 == 0) ? TAG_W'($urandom_range(0, 3)) : TAG_W'($urandom));
                ent_payload[i*PAYLOAD_W +: PAYLOAD_W] = {$urandom, $urandom, $urandom, $urandom};
            end
            issue_if.issue_ready = ISSUE_W'($urandom);
            step(1'b0, '0);
        end
        rst_n = 1'b1;
        defaults();
        step(1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
